// File: rtl/alu_flags_stage.sv
// alu_flags_stage: registered stage after the 32-bit subtractor.
// Evaluates the condition code against the committed NZCV, updates NZCV on
// S-bit instructions, and forwards results to writeback through a 2-entry
// skid buffer (output register + skid register) with a registered IN_READY.
module alu_flags_stage (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] IN_RESULT,
    input  logic        IN_COUT,
    input  logic        IN_OVERFLOW,
    input  logic        IN_SETFLAGS,
    input  logic [3:0]  IN_COND,
    input  logic [3:0]  IN_RD,
    input  logic        IN_WRITE,
    input  logic        FLAGS_LOAD,
    input  logic [3:0]  FLAGS_IN,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_RESULT,
    output logic [3:0]  OUT_RD,
    output logic        OUT_WE,
    output logic [3:0]  FLAGS,
    output logic        CARRY_FWD
);

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  rd;
        logic        we;
    } entry_t;

    entry_t     out_q, out_d, skid_q, skid_d, in_entry;
    logic       out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic       ready_q, ready_d;
    logic [3:0] flags_q, flags_d;
    logic       pass, accept, emit;
    logic       fn, fz, fc, fv;

    assign {fn, fz, fc, fv} = flags_q;
    assign accept   = IN_VALID & ready_q;
    assign emit     = out_vld_q & OUT_READY;
    assign in_entry = '{result: IN_RESULT, rd: IN_RD, we: pass & IN_WRITE};

    // Condition code evaluation against the committed flags
    always_comb begin
        pass = 1'b0;
        case (IN_COND)
            4'b0000: pass = fz;
            4'b0001: pass = ~fz;
            4'b0010: pass = fc;
            4'b0011: pass = ~fc;
            4'b0100: pass = fn;
            4'b0101: pass = ~fn;
            4'b0110: pass = fv;
            4'b0111: pass = ~fv;
            4'b1000: pass = fc & ~fz;
            4'b1001: pass = ~fc | fz;
            4'b1010: pass = (fn == fv);
            4'b1011: pass = (fn != fv);
            4'b1100: pass = ~fz & (fn == fv);
            4'b1101: pass = fz | (fn != fv);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    // Flag update: a direct load wins over an S-bit update on the same edge
    always_comb begin
        flags_d = flags_q;
        if (FLAGS_LOAD)
            flags_d = FLAGS_IN;
        else if (accept && pass && IN_SETFLAGS)
            flags_d = {IN_RESULT[31], (IN_RESULT == 32'd0), IN_COUT, IN_OVERFLOW};
    end

    // Skid buffer next state; skid entry only fills when the output is stalled
    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!out_vld_q) begin
            if (accept) begin
                out_d     = in_entry;
                out_vld_d = 1'b1;
            end
        end else if (!skid_vld_q) begin
            if (accept && emit) begin
                out_d = in_entry;
            end else if (accept) begin
                skid_d     = in_entry;
                skid_vld_d = 1'b1;
            end else if (emit) begin
                out_vld_d = 1'b0;
            end
        end else if (emit) begin
            out_d      = skid_q;
            skid_vld_d = 1'b0;
        end
        ready_d = ~(out_vld_d & skid_vld_d);
    end

    // State registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            ready_q    <= 1'b1;
            flags_q    <= 4'b0000;
        end else begin
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            ready_q    <= ready_d;
            flags_q    <= flags_d;
        end
    end

    assign IN_READY   = ready_q;
    assign OUT_VALID  = out_vld_q;
    assign OUT_RESULT = out_q.result;
    assign OUT_RD     = out_q.rd;
    assign OUT_WE     = out_q.we;
    assign FLAGS      = flags_q;
    assign CARRY_FWD  = flags_q[1];

endmodule

// File: tb/tb_alu_flags_stage.sv
// Scoreboard bench for alu_flags_stage: the driver pushes expected entries
// and tracks reference NZCV; a separate monitor pops on every emit.
module tb_alu_flags_stage;

    logic        CLK, RST_N;
    logic        IN_VALID, IN_READY, IN_COUT, IN_OVERFLOW, IN_SETFLAGS, IN_WRITE;
    logic [31:0] IN_RESULT, OUT_RESULT;
    logic [3:0]  IN_COND, IN_RD, FLAGS_IN, OUT_RD, FLAGS;
    logic        FLAGS_LOAD, OUT_VALID, OUT_READY, OUT_WE, CARRY_FWD;

    alu_flags_stage dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_RESULT(IN_RESULT), .IN_COUT(IN_COUT), .IN_OVERFLOW(IN_OVERFLOW),
        .IN_SETFLAGS(IN_SETFLAGS), .IN_COND(IN_COND), .IN_RD(IN_RD),
        .IN_WRITE(IN_WRITE), .FLAGS_LOAD(FLAGS_LOAD), .FLAGS_IN(FLAGS_IN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_RESULT(OUT_RESULT),
        .OUT_RD(OUT_RD), .OUT_WE(OUT_WE), .FLAGS(FLAGS), .CARRY_FWD(CARRY_FWD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  rd;
        logic        we;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    logic [3:0] fm = 4'b0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: even codes test a base predicate, odd codes invert it
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    // One cycle: drive at negedge, check committed state, model the edge
    task automatic step(input logic v, input logic [31:0] res, input logic co, input logic ov,
                        input logic s, input logic [3:0] cnd, input logic [3:0] rd,
                        input logic wr, input logic fl, input logic [3:0] fin,
                        input logic ordy, output logic acc);
        logic p;
        @(negedge CLK);
        IN_VALID = v; IN_RESULT = res; IN_COUT = co; IN_OVERFLOW = ov;
        IN_SETFLAGS = s; IN_COND = cnd; IN_RD = rd; IN_WRITE = wr;
        FLAGS_LOAD = fl; FLAGS_IN = fin; OUT_READY = ordy;
        #1;
        chk("flags", 32'(FLAGS), 32'(fm));
        chk("carry_fwd", 32'(CARRY_FWD), 32'(fm[1]));
        chk("in_ready", 32'(IN_READY), 32'(sb.size() < 2));
        acc = v & IN_READY;
        p = cond_pass(cnd, fm);
        if (acc) sb.push_back('{r: res, rd: rd, we: p & wr});
        if (fl) fm = fin;
        else if (acc && p && s) fm = {res[31], res == 32'd0, co, ov};
    endtask

    task automatic idle(input logic ordy);
        logic a;
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, ordy, a);
    endtask

    // Monitor: every handshake pops one expected entry
    always begin
        @(negedge CLK);
        #2;
        if (RST_N && OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                chk("unexpected_emit", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_result", OUT_RESULT, e.r);
                chk("out_rd", 32'(OUT_RD), 32'(e.rd));
                chk("out_we", 32'(OUT_WE), 32'(e.we));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic a;
        int   n;
        RST_N = 1'b0; IN_VALID = 1'b0; IN_RESULT = '0; IN_COUT = 1'b0; IN_OVERFLOW = 1'b0;
        IN_SETFLAGS = 1'b0; IN_COND = '0; IN_RD = '0; IN_WRITE = 1'b0;
        FLAGS_LOAD = 1'b0; FLAGS_IN = '0; OUT_READY = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_out_result", OUT_RESULT, 32'd0);
        chk("rst_out_rd", 32'(OUT_RD), 32'd0);
        chk("rst_out_we", 32'(OUT_WE), 32'd0);
        chk("rst_flags", 32'(FLAGS), 32'd0);
        chk("rst_carry", 32'(CARRY_FWD), 32'd0);
        chk("rst_in_ready", 32'(IN_READY), 32'd1);
        @(negedge CLK);
        RST_N = 1'b1;

        // SUBS result 0, AL, rd 3
        step(1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 4'b1110, 4'd3, 1'b1, 1'b0, 4'd0, 1'b1, a);
        idle(1'b1);
        chk("subs_latency_valid", 32'(OUT_VALID), 32'd1);
        chk("subs_flags", 32'(FLAGS), 32'(4'b0110));

        // CMP -> N,V set; then GE passes, LT fails
        step(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 4'b1110, 4'd1, 1'b0, 1'b0, 4'd0, 1'b1, a);
        step(1'b1, 32'd5, 1'b1, 1'b0, 1'b0, 4'b1010, 4'd2, 1'b1, 1'b0, 4'd0, 1'b1, a);
        chk("cmp_flags", 32'(FLAGS), 32'(4'b1001));
        step(1'b1, 32'd7, 1'b1, 1'b0, 1'b1, 4'b1011, 4'd4, 1'b1, 1'b0, 4'd0, 1'b1, a);
        idle(1'b1);
        chk("lt_fail_flags", 32'(FLAGS), 32'(4'b1001));

        // Condition sweep over every NZCV and every code
        for (int f = 0; f < 16; f++) begin
            step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'(f), 1'b1, a);
            for (int c = 0; c < 16; c++)
                step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 4'(c), 4'(c), 1'b1, 1'b0, 4'd0, 1'b1, a);
        end
        repeat (2) idle(1'b1);

        // Backpressure: two held, third waits
        step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 4'b1110, 4'd10, 1'b1, 1'b0, 4'd0, 1'b0, a);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 4'b1110, 4'd11, 1'b1, 1'b0, 4'd0, 1'b0, a);
        step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 4'b1110, 4'd12, 1'b1, 1'b0, 4'd0, 1'b0, a);
        chk("bp_full_ready", 32'(IN_READY), 32'd0);
        step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 4'b1110, 4'd12, 1'b1, 1'b0, 4'd0, 1'b0, a);
        chk("bp_held_valid", 32'(OUT_VALID), 32'd1);
        n = 0;
        do begin
            step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 4'b1110, 4'd12, 1'b1, 1'b0, 4'd0, 1'b1, a);
            n++;
        end while (!a && n < 10);
        chk("bp_third_accepted", 32'(a), 32'd1);
        repeat (3) idle(1'b1);
        chk("bp_drained", 32'(sb.size()), 32'd0);

        // FLAGS_LOAD beats SETFLAGS on the same edge
        step(1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 4'b1110, 4'd6, 1'b1, 1'b1, 4'b1010, 1'b1, a);
        idle(1'b1);
        chk("prio_flags", 32'(FLAGS), 32'(4'b1010));

        // Asynchronous reset with two entries buffered
        step(1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 4'b1110, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0, a);
        step(1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 4'b1110, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0, a);
        @(negedge CLK);
        IN_VALID = 1'b0;
        #3;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("mid_rst_flags", 32'(FLAGS), 32'd0);
        chk("mid_rst_in_ready", 32'(IN_READY), 32'd1);
        sb.delete();
        fm = 4'b0000;
        @(negedge CLK);
        RST_N = 1'b1;
        step(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 4'b1110, 4'd5, 1'b1, 1'b0, 4'd0, 1'b1, a);
        idle(1'b1);
        chk("post_rst_valid", 32'(OUT_VALID), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] r;
            case ($urandom_range(0, 3))
                0: r = 32'd0;
                1: r = 32'h8000_0000;
                default: r = $urandom;
            endcase
            step(1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), a);
        end
        repeat (4) idle(1'b1);
        chk("final_drain", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
